// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the NOP encoding, the fetch FSM state encoding, the default reset PC
// and the layout of one buffered {pc, insn} entry. Opcode constants used by
// the decoder are defined alongside the decoder, not here.
package instruction_fetch_pkg;

    localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // S_REQ : may issue a request (if buffer space is available)
    // S_WAIT: exactly one request in flight, its response will be kept
    // S_DROP: exactly one request in flight, its response will be discarded
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } fetch_entry_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_fetch_fifo.sv
// fetch_fifo: small instruction buffer of DEPTH x {pc, insn} entries.
// Head entry is visible combinationally. Flush clears the buffer and
// overrides any push/pop in the same cycle. Push and pop together are legal
// at any occupancy, including full. DEPTH must be a power of two >= 2.
module fetch_fifo
    import instruction_fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    output fetch_entry_t  head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;
    fetch_entry_t  slot_q [DEPTH];

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // A pop frees the slot the push may need, so push-while-full is fine
    // when a pop happens in the same cycle.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;

    // Pointer and occupancy bookkeeping; flush wins over everything.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer/count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage: contents are only meaningful below count, so no reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic wr_en;
            assign wr_en = do_push && (wr_ptr_q == AW'(gi));
            // Capture the pushed entry into this slot.
            always_ff @(posedge clk) begin
                if (wr_en) slot_q[gi] <= push_data;
            end
        end
    endgenerate

    assign head_data = slot_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner and fetch stage in front of the decoder.
// Issues one word read at a time to instruction memory (valid/ready request,
// valid-only response), buffers returned words in fetch_fifo and presents
// {ins, ins_pc} to decode. Redirects from execute flush the buffer and mark
// any in-flight response as stale.
// Optional build macro: FETCH_MISALIGN_CHECK_EN enables a sticky fetch_fault
// on redirects to non-word-aligned targets; without it the target's low two
// bits are ignored and fetch_fault is constant 0.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic          req_hs;
    logic          fault_active;
    logic          redir_bad;
    logic [31:0]   redir_target;
    logic [CW-1:0] free_slots;

    logic          fifo_push, fifo_pop, fifo_flush;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head, fifo_push_data;
    logic          unused_ok;

    assign redir_target = word_align(redirect_pc);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Every redirect decides the fault flag: misaligned sets, aligned clears.
    always_comb begin
        fault_d = fault_q;
        if (redirect_valid) fault_d = redir_bad;
    end

    // Sticky fault flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fault_q <= 1'b0;
        else     fault_q <= fault_d;
    end

    assign fault_active = fault_q;
    assign fetch_fault  = fault_q;
    assign unused_ok    = fifo_full;
`else
    assign redir_bad    = 1'b0;
    assign fault_active = 1'b0;
    assign fetch_fault  = 1'b0;
    // Low target bits are deliberately ignored in this build.
    assign unused_ok    = ^{redirect_pc[1:0], fifo_full, redir_bad};
`endif

    assign free_slots = CW'(FIFO_DEPTH) - fifo_count;
    assign req_hs     = imem_req_valid & imem_req_ready;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_REQ;
        else     state_q <= state_d;
    end

    // FSM next state: a redirect turns whatever is (or becomes) in flight stale.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (req_hs) state_d = redirect_valid ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid)      state_d = imem_rsp_valid ? S_REQ : S_DROP;
                else if (imem_rsp_valid) state_d = S_REQ;
            end
            S_DROP: begin
                if (imem_rsp_valid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // FSM outputs: request gating, buffer push/pop/flush.
    always_comb begin
        imem_req_valid = 1'b0;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        fifo_flush     = redirect_valid;
        // Space is reserved before issuing, so the response always fits.
        if (!rst && state_q == S_REQ && free_slots != '0 && !fault_active)
            imem_req_valid = 1'b1;
        if (state_q == S_WAIT && imem_rsp_valid && !redirect_valid)
            fifo_push = 1'b1;
        if (ins_valid && ins_ready && !redirect_valid)
            fifo_pop = 1'b1;
    end

    // PC and request-address update; redirect beats the handshake increment.
    always_comb begin
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        if (req_hs) req_addr_d = pc_q;
        if (redirect_valid) pc_d = redir_target;
        else if (req_hs)    pc_d = pc_q + 32'd4;
    end

    // PC and request-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    assign imem_addr         = pc_q;
    assign fifo_push_data.pc   = req_addr_q;
    assign fifo_push_data.insn = imem_rdata;

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (fifo_flush),
        .push     (fifo_push),
        .push_data(fifo_push_data),
        .pop      (fifo_pop),
        .head_data(fifo_head),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign ins_valid = ~fifo_empty;
    assign ins       = fifo_empty ? NOP_INSN : fifo_head.insn;
    assign ins_pc    = fifo_empty ? 32'h0000_0000 : fifo_head.pc;

endmodule
